// File: rtl/mp_accum_pkg.sv
// Shared types and segment constants for the mixed-precision accumulate unit.
package mp_accum_pkg;

    typedef enum logic [1:0] {
        W32 = 2'd0,
        H16 = 2'd1,
        B8  = 2'd2,
        RED = 2'd3
    } mp_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } mp_state_e;

    localparam int unsigned SEG16 = 16;
    localparam int unsigned SEG8  = 8;

endpackage

// File: rtl/mp_seg_adder.sv
// Combinational adder whose carry chain is cut at 8- or 16-bit borders by mode;
// each segment wraps around independently.
module mp_seg_adder
    import mp_accum_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] sum_o
);

    localparam int unsigned NB  = DATA_W / SEG8;
    localparam int unsigned BPS = SEG16 / SEG8;
    localparam int unsigned PW  = SEG8 + 1;

    logic          carry;
    logic [PW-1:0] part;

    // Byte-wise ripple; the carry into a byte is dropped at segment starts.
    always_comb begin
        sum_o = '0;
        carry = 1'b0;
        part  = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (mode_i == B8 || (mode_i != W32 && (i % int'(BPS)) == 0)) begin
                carry = 1'b0;
            end
            part = PW'(a_i[i*SEG8 +: SEG8]) + PW'(b_i[i*SEG8 +: SEG8]) + PW'(carry);
            sum_o[i*SEG8 +: SEG8] = part[SEG8-1:0];
            carry = part[SEG8];
        end
    end

endmodule

// File: rtl/mp_accum_unit.sv
// Pipelined SIMD add/accumulate unit: segmented lane adds (S1), multi-beat
// accumulation (S2), and a valid/ready result port with a drain phase.
module mp_accum_unit
    import mp_accum_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FIELD_W   = 12,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [1:0]                    mode_i,
    input  logic                          last_i,
    input  logic [NUM_LANES*DATA_W-1:0]   p_a_i,
    input  logic [NUM_LANES*DATA_W-1:0]   p_b_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NUM_LANES*DATA_W-1:0]   sums_o,
    output logic [CNT_W-1:0]              beat_cnt_o
);

    localparam int unsigned HALF = NUM_LANES / 2;

    mp_state_e state_q;
    mp_mode_e  mode_q;
    mp_mode_e  mode_eff;
    logic      beat_acc;
    logic      drain_q;
    logic      valid_q;
    logic [CNT_W-1:0] beat_cnt_q;

    logic [NUM_LANES-1:0][DATA_W-1:0] lane_sum;
    logic [NUM_LANES-1:0][DATA_W-1:0] s1_sum_q;
    logic [NUM_LANES-1:0][DATA_W-1:0] acc_q;
    logic [NUM_LANES-1:0][DATA_W-1:0] acc_in;
    logic [NUM_LANES-1:0][DATA_W-1:0] acc_add;
    logic [NUM_LANES-1:0][DATA_W-1:0] acc_d;
    logic [NUM_LANES-1:0][DATA_W-1:0] sums_fmt;
    logic [NUM_LANES-1:0][DATA_W-1:0] sums_q;
    logic [DATA_W-1:0] half_lo, half_hi, red_sum, s1_red_q;
    logic              s1_vld_q, s1_first_q;

    assign ready_o    = (state_q == IDLE) || (state_q == ACC);
    assign beat_acc   = valid_i && ready_o;
    assign mode_eff   = (state_q == IDLE) ? mp_mode_e'(mode_i) : mode_q;
    assign valid_o    = valid_q;
    assign sums_o     = sums_q;
    assign beat_cnt_o = beat_cnt_q;

    function automatic logic [DATA_W-1:0] add16(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int s = 0; s < int'(DATA_W / SEG16); s++) begin
            r[s*SEG16 +: SEG16] = a[s*SEG16 +: SEG16] + b[s*SEG16 +: SEG16];
        end
        return r;
    endfunction

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mp_seg_adder #(.DATA_W(DATA_W)) u_s1 (
            .a_i   (p_a_i[l*DATA_W +: DATA_W]),
            .b_i   (p_b_i[l*DATA_W +: DATA_W]),
            .mode_i(mode_eff),
            .sum_o (lane_sum[l])
        );

        // In reduction mode only lane 0 accumulates; the rest stay zero.
        assign acc_in[l] = (mode_q == RED) ? ((l == 0) ? s1_red_q : '0) : s1_sum_q[l];

        mp_seg_adder #(.DATA_W(DATA_W)) u_s2 (
            .a_i   (acc_q[l]),
            .b_i   (acc_in[l]),
            .mode_i(mode_q),
            .sum_o (acc_add[l])
        );

        assign acc_d[l] = (mode_q == RED && l != 0) ? '0
                        : (s1_first_q ? acc_in[l] : acc_add[l]);
    end

    // Cross-lane reduction: fold each half, then one segmented add joins them.
    always_comb begin
        half_lo = '0;
        half_hi = '0;
        for (int l = 0; l < int'(HALF); l++) begin
            half_lo = add16(half_lo, lane_sum[l]);
            half_hi = add16(half_hi, lane_sum[l + int'(HALF)]);
        end
    end

    mp_seg_adder #(.DATA_W(DATA_W)) u_red (
        .a_i   (half_lo),
        .b_i   (half_hi),
        .mode_i(RED),
        .sum_o (red_sum)
    );

    always_comb begin
        sums_fmt = acc_q;
        if (mode_q == RED) begin
            sums_fmt    = '0;
            sums_fmt[0] = {{(DATA_W-FIELD_W){acc_q[0][SEG16+FIELD_W-1]}}, acc_q[0][SEG16 +: FIELD_W]};
            sums_fmt[1] = {{(DATA_W-FIELD_W){acc_q[0][FIELD_W-1]}}, acc_q[0][FIELD_W-1:0]};
        end
    end

    // S1 and S2 pipeline registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_red_q   <= '0;
            acc_q      <= '0;
        end else begin
            s1_vld_q <= beat_acc;
            if (beat_acc) begin
                s1_first_q <= (state_q == IDLE);
                s1_sum_q   <= lane_sum;
                s1_red_q   <= red_sum;
            end
            if (s1_vld_q) begin
                acc_q <= acc_d;
            end
        end
    end

    // Group FSM with beat counter, drain timer and registered result port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mode_q     <= W32;
            drain_q    <= 1'b0;
            beat_cnt_q <= '0;
            valid_q    <= 1'b0;
            sums_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat_acc) begin
                        mode_q     <= mode_eff;
                        beat_cnt_q <= CNT_W'(1);
                        drain_q    <= 1'b0;
                        state_q    <= last_i ? DRAIN : ACC;
                    end
                end
                ACC: begin
                    if (beat_acc) begin
                        if (beat_cnt_q != {CNT_W{1'b1}}) begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                        if (last_i) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        drain_q <= 1'b0;
                        state_q <= OUT;
                        valid_q <= 1'b1;
                        sums_q  <= sums_fmt;
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
